// File: rtl/up_down_counter_cfg.sv
// up_down_counter_cfg
//   WIDTH-bit up/down counter with run-time programmable inclusive limits.
//   Supports wrap or saturate at the limits (selectable per cycle), synchronous
//   clear, clamped parallel load, and a registered one-cycle wrap pulse.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (count=RST_VAL, wrap=0)
//   clr       synchronous clear to cfg_min
//   load      synchronous load of load_val, clamped into [cfg_min, cfg_max]
//   load_val  value to load
//   en        count enable
//   up        1 = increment, 0 = decrement
//   sat_mode  1 = saturate at limits, 0 = wrap between limits
//   cfg_min   lower limit (inclusive, unsigned)
//   cfg_max   upper limit (inclusive, unsigned)
//   count     registered counter value
//   at_max    count == cfg_max (combinational)
//   at_min    count == cfg_min (combinational)
//   wrap      one-cycle pulse: a wrap occurred on the last edge
//   cfg_err   cfg_min > cfg_max (combinational); freezes the counter
module up_down_counter_cfg #(
  parameter int WIDTH   = 4,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] cfg_min,
  input  logic [WIDTH-1:0] cfg_max,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             cfg_err
);

  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  // Clamp a value into the inclusive range [lo, hi]; caller guarantees lo <= hi.
  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] val,
                                             input logic [WIDTH-1:0] lo,
                                             input logic [WIDTH-1:0] hi);
    logic [WIDTH-1:0] res;
    res = val;
    if (val < lo) res = lo;
    else if (val > hi) res = hi;
    return res;
  endfunction

  assign cfg_err = (cfg_min > cfg_max);
  assign at_max  = (count == cfg_max);
  assign at_min  = (count == cfg_min);

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (cfg_err) begin
      count_nxt = count;
    end else if (clr) begin
      count_nxt = cfg_min;
    end else if (load) begin
      count_nxt = clamp(load_val, cfg_min, cfg_max);
    end else if (en) begin
      if ((count > cfg_max) || (count < cfg_min)) begin
        // Limits moved under the counter: snap to the limit we count away from.
        count_nxt = up ? cfg_min : cfg_max;
      end else if (up) begin
        if (count < cfg_max) begin
          count_nxt = count + ONE;
        end else if (!sat_mode) begin
          count_nxt = cfg_min;
          wrap_nxt  = 1'b1;
        end
      end else begin
        if (count > cfg_min) begin
          count_nxt = count - ONE;
        end else if (!sat_mode) begin
          count_nxt = cfg_max;
          wrap_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_CNT;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_up_down_counter_cfg.sv
module tb_up_down_counter_cfg;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr, load, en, up, sat_mode;
  logic [W-1:0] load_val, cfg_min, cfg_max;
  logic [W-1:0] count;
  logic         at_max, at_min, wrap, cfg_err;

  int n_cmp  = 0;
  int n_fail = 0;

  up_down_counter_cfg #(.WIDTH(W), .RST_VAL(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .sat_mode(sat_mode), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .count(count), .at_max(at_max), .at_min(at_min), .wrap(wrap), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 0; load = 0; en = 0; up = 1; sat_mode = 0; load_val = '0;
  endtask

  task automatic do_load(input int v);
    idle(); load = 1; load_val = W'(v);
    tick();
    load = 0;
  endtask

  task automatic chk_cw(input string name, input int exp_c, input bit exp_w);
    n_cmp++;
    if (count !== W'(exp_c) || wrap !== exp_w) begin
      n_fail++;
      $display("FAIL %s: count=%0d wrap=%0b, required count=%0d wrap=%0b",
               name, count, wrap, exp_c, exp_w);
    end
  endtask

  task automatic test_reset();
    idle(); cfg_min = 0; cfg_max = 15; rst_n = 0;
    tick(); tick();
    rst_n = 1;
    do_load(9);
    chk_cw("reset_preload", 9, 0);
    #3 rst_n = 0;
    #1;
    n_cmp++;
    if (count !== 4'd0 || wrap !== 1'b0 || at_min !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: count=%0d wrap=%0b at_min=%0b, required 0 0 1",
               count, wrap, at_min);
    end
    en = 1; up = 1;
    @(negedge clk);
    rst_n = 1;
    tick();
    chk_cw("reset_first_edge", 1, 0);
  endtask

  task automatic test_wrap();
    cfg_min = 3; cfg_max = 12;
    do_load(11);
    en = 1; up = 1; sat_mode = 0;
    tick(); chk_cw("wrap_up_12", 12, 0);
    n_cmp++;
    if (at_max !== 1'b1) begin n_fail++; $display("FAIL wrap_at_max: at_max=%0b required 1", at_max); end
    tick(); chk_cw("wrap_up_to_min", 3, 1);
    tick(); chk_cw("wrap_up_4", 4, 0);
    up = 0;
    tick(); chk_cw("wrap_dn_3", 3, 0);
    tick(); chk_cw("wrap_dn_to_max", 12, 1);
    tick(); chk_cw("wrap_dn_11", 11, 0);
  endtask

  task automatic test_saturate();
    cfg_min = 3; cfg_max = 12;
    do_load(10);
    en = 1; up = 1; sat_mode = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_cw("sat_up", (i < 2) ? 11 + i : 12, 0);
    end
    do_load(3);
    en = 1; up = 0; sat_mode = 1;
    tick(); chk_cw("sat_dn_hold", 3, 0);
    tick(); chk_cw("sat_dn_hold2", 3, 0);
  endtask

  task automatic test_load();
    cfg_min = 3; cfg_max = 12;
    do_load(15); chk_cw("load_clamp_hi", 12, 0);
    do_load(1);  chk_cw("load_clamp_lo", 3, 0);
    do_load(8);  chk_cw("load_in_range", 8, 0);
    idle(); clr = 1; load = 1; load_val = 10;
    tick(); chk_cw("clr_beats_load", 3, 0);
    idle(); load = 1; load_val = 7; en = 1; up = 1;
    tick(); chk_cw("load_beats_en", 7, 0);
  endtask

  task automatic test_out_of_range();
    cfg_min = 3; cfg_max = 12;
    do_load(10);
    cfg_max = 7; en = 1; up = 1; sat_mode = 0;
    tick(); chk_cw("oor_up_snap_min", 3, 0);
    cfg_min = 5; cfg_max = 9; up = 0;
    tick(); chk_cw("oor_dn_snap_max", 9, 0);
    cfg_min = 9; cfg_max = 5;
    #1;
    n_cmp++;
    if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_flag: cfg_err=%0b required 1", cfg_err); end
    clr = 1; load = 1; load_val = 2; en = 1;
    tick(); chk_cw("cfg_err_hold", 9, 0);
    clr = 0; load = 0;
    tick(); chk_cw("cfg_err_hold_en", 9, 0);
  endtask

  task automatic test_degenerate();
    cfg_min = 6; cfg_max = 6;
    idle(); clr = 1; tick(); clr = 0;
    en = 1; up = 1; sat_mode = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) up = 0;
      tick();
      chk_cw("degen_wrap", 6, 1);
      n_cmp++;
      if (at_min !== 1'b1 || at_max !== 1'b1) begin
        n_fail++;
        $display("FAIL degen_flags: at_min=%0b at_max=%0b required 1 1", at_min, at_max);
      end
    end
    en = 0;
    tick(); chk_cw("degen_idle", 6, 0);
  endtask

  // Reference model: counts are treated as plain integers positioned in a
  // ring of (hi-lo+1) slots for wrap mode, or clipped for saturate mode.
  task automatic test_random();
    int m_c, m_w, lo, hi, lv, off, span, nc, nw;
    cfg_min = 2; cfg_max = 13;
    idle(); clr = 1; tick(); clr = 0;
    m_c = 2; m_w = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // drive
      rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        lo = $urandom_range(0, 15); hi = $urandom_range(0, 15);
        if ($urandom_range(0, 4) != 0 && lo > hi) begin int t; t = lo; lo = hi; hi = t; end
        cfg_min = W'(lo); cfg_max = W'(hi);
      end
      clr = ($urandom_range(0, 99) < 5);
      load = ($urandom_range(0, 99) < 10);
      load_val = W'($urandom);
      en = ($urandom_range(0, 99) < 75);
      up = W'($urandom) > 4'd5;
      sat_mode = ($urandom_range(0, 2) == 0);
      // predict
      lo = int'(cfg_min); hi = int'(cfg_max); lv = int'(load_val);
      nc = m_c; nw = 0;
      if (!rst_n) nc = 0;
      else if (lo > hi) nc = m_c;
      else if (clr) nc = lo;
      else if (load) nc = (lv < lo) ? lo : ((lv > hi) ? hi : lv);
      else if (en) begin
        if (m_c < lo || m_c > hi) nc = up ? lo : hi;
        else if (sat_mode) nc = up ? ((m_c + 1 > hi) ? hi : m_c + 1)
                                   : ((m_c - 1 < lo) ? lo : m_c - 1);
        else begin
          span = hi - lo + 1;
          off = m_c - lo + (up ? 1 : -1);
          if (off < 0 || off >= span) nw = 1;
          nc = lo + ((off % span) + span) % span;
        end
      end
      m_c = nc; m_w = nw;
      tick();
      n_cmp++;
      if (count !== W'(m_c) || wrap !== m_w[0] || at_max !== (m_c == hi) ||
          at_min !== (m_c == lo) || cfg_err !== (lo > hi)) begin
        n_fail++;
        $display("FAIL rand cyc%0d: count=%0d wrap=%0b atmax=%0b atmin=%0b err=%0b, required %0d %0d %0b %0b %0b",
                 cyc, count, wrap, at_max, at_min, cfg_err, m_c, m_w,
                 (m_c == hi), (m_c == lo), (lo > hi));
      end
    end
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; idle(); cfg_min = 0; cfg_max = 15;
    test_reset();
    test_wrap();
    test_saturate();
    test_load();
    test_out_of_range();
    test_degenerate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/up_down_counter_cfg.md
Name: up_down_counter_cfg

Overview:
Parametrised successor of the 4-bit up/down counter. It is a WIDTH-bit up/down counter with enable, synchronous clear, parallel load, run-time programmable lower/upper limits, and wrap or saturate selection per cycle. It provides boundary flags and a registered wrap pulse for use as a programmable modulo counter / timer building block in downstream control logic.

Parameters:
WIDTH, 4, counter and limit width in bits (>=2)
RST_VAL, 0, count value on asynchronous reset (must fit WIDTH bits)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear to cfg_min
load  in  1  synchronous parallel load of load_val
load_val  in  WIDTH  value to load (clamped into range)
en  in  1  count enable
up  in  1  direction: 1 = increment, 0 = decrement
sat_mode  in  1  1 = saturate at limits, 0 = wrap between limits
cfg_min  in  WIDTH  lower limit, inclusive, unsigned
cfg_max  in  WIDTH  upper limit, inclusive, unsigned
count  out  WIDTH  registered counter value
at_max  out  1  combinational: count == cfg_max
at_min  out  1  combinational: count == cfg_min
wrap  out  1  registered one-cycle pulse: a wrap occurred on the last edge
cfg_err  out  1  combinational: cfg_min > cfg_max

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low. While rst_n=0: count=RST_VAL, wrap=0. Deassertion takes effect from the next rising edge.
- Reset overrides everything, including mid-count, mid-load and mid-wrap.
- Per-edge priority (all unsigned): cfg_err > clr > load > en > hold.
  - cfg_err=1: count holds; wrap=0; clr, load and en are ignored.
  - clr=1: count<=cfg_min; wrap<=0.
  - load=1: count<=load_val clamped to [cfg_min,cfg_max] (below min -> min, above max -> max); wrap<=0.
  - en=1, up=1:
    - count<cfg_max: count+1.
    - count==cfg_max: sat_mode=1 -> hold, wrap<=0; sat_mode=0 -> count<=cfg_min, wrap<=1.
  - en=1, up=0:
    - count>cfg_min: count-1.
    - count==cfg_min: sat_mode=1 -> hold, wrap<=0; sat_mode=0 -> count<=cfg_max, wrap<=1.
  - en=0: count holds; wrap<=0.
- Out-of-range recovery: count can fall outside the limits after cfg_min/cfg_max change at run time. With en=1, count>cfg_max or count<cfg_min snaps to cfg_min (up=1) or cfg_max (up=0) on that edge. wrap<=0; no arithmetic step is taken.
- Arithmetic: WIDTH-bit, no carry out. Natural 2^WIDTH rollover never occurs because limits govern wrapping. With cfg_min=0 and cfg_max=all-ones, behaviour equals a plain mod-2^WIDTH counter, but wrap pulses.
- Degenerate range cfg_min==cfg_max: count stays at that value. at_max=at_min=1. With en=1 and sat_mode=0, wrap pulses every enabled cycle.
- wrap is high for exactly one cycle per wrap event. Consecutive enabled wraps give consecutive pulses.
- up and sat_mode may change on any cycle and are sampled at each edge. There is no pipeline; latency from inputs to count is 1 cycle.
- at_max, at_min and cfg_err are combinational from the registered count and the current cfg inputs. They are valid during reset against RST_VAL.

Test Plan:
- WIDTH=4, rst_n=0 asynchronously mid-cycle with count=9 -> count=0 and wrap=0 immediately, before the next edge; first edge after release with en=1, up=1 -> count=1.
- cfg_min=3, cfg_max=12, sat_mode=0, en=1, up=1 from 11 -> 12 (at_max=1), then 3 with wrap=1 for one cycle, then 4 with wrap=0; repeat with up=0 from 4 -> 3 -> 12 with wrap pulse.
- Same limits, sat_mode=1, up=1 held 5 cycles from 10 -> 11, 12, 12, 12, 12, wrap never asserted; up=0 at 3 -> holds 3.
- load=1, load_val=15, limits 3..12 -> count=12; load_val=1 -> count=3; same edge with clr=1 and load=1 -> count=3 (clr wins); load=1 with en=1 -> load wins.
- count=10, cfg_max changed to 7, en=1, up=1 -> count=cfg_min, wrap=0; then cfg_min=9, cfg_max=5 -> cfg_err=1 and count holds despite en/clr/load.
- cfg_min=cfg_max=6, sat_mode=0, en=1 for 3 cycles -> count=6, at_min=at_max=1, wrap=1 each cycle; en=0 -> wrap=0.
